ad1939_adc_rx: RTL

- Deserializes the AD1939 ADC serial outputs (ASDATA1/ASDATA2) into per-channel parallel samples on the fabric clock.
- Runs in I2S mode with the codec as bus master, so ABCLK and ALRCLK are inputs.
- Sits between the `ad1939_physical` ADC pins and the audio processing path, and emits Avalon-ST words tagged with channel number.
- ABCLK and ALRCLK are oversampled; no second clock domain is used.

---
 rtl/ad1939_adc_rx.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ad1939_adc_rx.sv
// AD1939 ADC I2S receiver: oversamples codec-mastered ABCLK/ALRCLK and deserializes ASDATA1/2.
// Defining AD1939_RX_FRAME_CHECK_EN adds frame_err_count for half-frame length checking.
module ad1939_adc_rx #(
   parameter int unsigned DATA_WIDTH  = 24,
   parameter int unsigned SLOT_BITS   = 32,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  abclk_in,
   input  logic                  alrclk_in,
   input  logic                  asdata1_in,
   input  logic                  asdata2_in,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            out_channel,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  overflow,
   input  logic                  clear_overflow
`ifdef AD1939_RX_FRAME_CHECK_EN
   ,
   output logic [15:0]           frame_err_count
`endif
);
   localparam int unsigned CW   = $clog2(SLOT_BITS + 1);
   localparam int unsigned AW   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNTW = AW + 1;
   localparam int unsigned EW   = DATA_WIDTH + 2;

   typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

   logic [SYNC_STAGES-1:0] r_sync_bclk, r_sync_lr, r_sync_d1, r_sync_d2;
   logic                   r_bclk_q, r_rise, r_lr, r_d1, r_d2, r_lr_prev;
   state_t                 r_state;
   logic [CW-1:0]          r_bit_cnt;
   logic [DATA_WIDTH-1:0]  r_sh1, r_sh2;
   logic                   r_slot_lr, r_chan_lr, r_push1, r_push2;
   logic [EW-1:0]          r_mem [FIFO_DEPTH];
   logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
   logic [CNTW-1:0]        r_count;

   logic                   w_bclk_s, w_lr_chg, w_push, w_pop, w_full, w_wr_ok, w_drop;
   logic [EW-1:0]          w_wdata, w_head_nxt;
   logic [AW-1:0]          w_rd_nxt;
   logic [CNTW-1:0]        w_count_nxt;

   assign w_bclk_s = r_sync_bclk[SYNC_STAGES-1];
   assign w_lr_chg = r_rise & (r_lr ^ r_lr_prev);

   // Synchronizers plus one stage that registers the ABCLK rise with its sampled LR/data.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sync_bclk <= '0;
         r_sync_lr   <= '0;
         r_sync_d1   <= '0;
         r_sync_d2   <= '0;
         r_bclk_q    <= 1'b0;
         r_rise      <= 1'b0;
         r_lr        <= 1'b0;
         r_d1        <= 1'b0;
         r_d2        <= 1'b0;
      end else begin
         r_sync_bclk <= {r_sync_bclk[SYNC_STAGES-2:0], abclk_in};
         r_sync_lr   <= {r_sync_lr[SYNC_STAGES-2:0], alrclk_in};
         r_sync_d1   <= {r_sync_d1[SYNC_STAGES-2:0], asdata1_in};
         r_sync_d2   <= {r_sync_d2[SYNC_STAGES-2:0], asdata2_in};
         r_bclk_q    <= w_bclk_s;
         r_rise      <= w_bclk_s & ~r_bclk_q;
         r_lr        <= r_sync_lr[SYNC_STAGES-1];
         r_d1        <= r_sync_d1[SYNC_STAGES-1];
         r_d2        <= r_sync_d2[SYNC_STAGES-1];
      end
   end

   // Slot FSM: the LR-change rise carries the previous slot's last bit, so capture starts one rise later.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_bit_cnt <= '0;
         r_sh1     <= '0;
         r_sh2     <= '0;
         r_slot_lr <= 1'b0;
         r_chan_lr <= 1'b0;
         r_lr_prev <= 1'b0;
         r_push1   <= 1'b0;
         r_push2   <= 1'b0;
      end else begin
         r_push1 <= 1'b0;
         r_push2 <= r_push1;
         if (r_rise) r_lr_prev <= r_lr;
         case (r_state)
            S_IDLE: begin
               if (enable && w_lr_chg) begin
                  r_state   <= S_ACTIVE;
                  r_bit_cnt <= '0;
                  r_slot_lr <= r_lr;
               end
            end
            S_ACTIVE: begin
               if (!enable) begin
                  r_state   <= S_IDLE;
                  r_bit_cnt <= '0;
               end else if (w_lr_chg) begin
                  r_bit_cnt <= '0;
                  r_slot_lr <= r_lr;
               end else if (r_rise) begin
                  if (r_bit_cnt < CW'(DATA_WIDTH)) begin
                     r_sh1 <= {r_sh1[DATA_WIDTH-2:0], r_d1};
                     r_sh2 <= {r_sh2[DATA_WIDTH-2:0], r_d2};
                  end
                  if (r_bit_cnt == CW'(DATA_WIDTH - 1)) begin
                     r_push1   <= 1'b1;
                     r_chan_lr <= r_slot_lr;
                  end
                  if (r_bit_cnt < CW'(SLOT_BITS)) r_bit_cnt <= r_bit_cnt + CW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Channel code is {adc2, right}; ADC1 word is pushed one cycle ahead of ADC2.
   assign w_push      = r_push1 | r_push2;
   assign w_wdata     = r_push1 ? {1'b0, r_chan_lr, r_sh1} : {1'b1, r_chan_lr, r_sh2};
   assign w_pop       = out_valid & out_ready;
   assign w_full      = (r_count == CNTW'(FIFO_DEPTH));
   assign w_wr_ok     = w_push & (~w_full | w_pop);
   assign w_drop      = w_push & w_full & ~w_pop;
   assign w_rd_nxt    = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
   assign w_count_nxt = r_count + CNTW'(w_wr_ok) - CNTW'(w_pop);
   assign w_head_nxt  = (w_wr_ok && (r_wr_ptr == w_rd_nxt)) ? w_wdata : r_mem[w_rd_nxt];

   always_ff @(posedge clk) begin
      if (w_wr_ok) r_mem[r_wr_ptr] <= w_wdata;
   end

   // Outputs present the next head so they stay registered without a read bypass.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         out_channel <= '0;
         overflow    <= 1'b0;
      end else begin
         if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         r_rd_ptr  <= w_rd_nxt;
         r_count   <= w_count_nxt;
         out_valid <= (w_count_nxt != '0);
         if (w_count_nxt != '0) begin
            out_data    <= w_head_nxt[DATA_WIDTH-1:0];
            out_channel <= w_head_nxt[EW-1 -: 2];
         end else begin
            out_data    <= '0;
            out_channel <= '0;
         end
         if (w_drop) overflow <= 1'b1;
         else if (clear_overflow) overflow <= 1'b0;
      end
   end

`ifdef AD1939_RX_FRAME_CHECK_EN
   localparam int unsigned HW = CW + 1;
   logic [HW-1:0] r_hf_cnt;
   logic          r_chk_armed;

   // Counts rises per LR phase, including the change rise; the slot in progress at entry is skipped.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_hf_cnt        <= HW'(1);
         r_chk_armed     <= 1'b0;
         frame_err_count <= '0;
      end else if (r_state == S_IDLE) begin
         r_hf_cnt    <= HW'(1);
         r_chk_armed <= 1'b0;
      end else if (w_lr_chg) begin
         r_hf_cnt    <= HW'(1);
         r_chk_armed <= 1'b1;
         if (r_chk_armed && (r_hf_cnt != HW'(SLOT_BITS)) && (frame_err_count != 16'hFFFF))
            frame_err_count <= frame_err_count + 16'd1;
      end else if (r_rise && (r_hf_cnt != '1)) begin
         r_hf_cnt <= r_hf_cnt + HW'(1);
      end
   end
`endif

endmodule
